// File: rtl/common_pkg.sv
// Shared width constants for the EconoPET simulation environment.
// Pure constants, no logic; zero latency.
// No flow control; consumed by parameter defaults only.
package common_pkg;
   localparam int CPU_ADDR_WIDTH = 16;
   localparam int DATA_WIDTH     = 8;
endpackage

// File: rtl/mock_pkg.sv
// Types and lane indices for the simulation bus mock.
// Pure declarations, no logic; zero latency.
// No flow control.
package mock_pkg;
   typedef enum logic [1:0] {
      DRIVEN    = 2'd0,
      KEEPING   = 2'd1,
      FLOATING  = 2'd2,
      CONTENDED = 2'd3
   } lane_state_e;

   localparam int LANE_ADDR = 0;
   localparam int LANE_DATA = 1;
   localparam int LANE_WE_N = 2;
endpackage

// File: rtl/mock_bus_lane.sv
// One resolved bus lane: agent mux, driver count, keeper hold with decay.
// Resolution is combinational (zero latency); keeper state updates on the clock edge.
// No backpressure; contention is reported, never blocked.
module mock_bus_lane
   import mock_pkg::*;
#(
   parameter int               WIDTH          = 8,
   parameter int               NUM_AGENTS     = 4,
   parameter int               KEEPER_CYCLES  = 3,
   parameter logic [WIDTH-1:0] UNDRIVEN_VALUE = 'x
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_AGENTS-1:0]         lane_oe,
   input  logic [NUM_AGENTS*WIDTH-1:0]   lane_vals,
   output logic [WIDTH-1:0]              lane_out,
   output logic                          lane_valid,
   output logic                          lane_contended
);
   localparam int PCW = $clog2(NUM_AGENTS + 1);
   localparam int KCW = (KEEPER_CYCLES > 0) ? $clog2(KEEPER_CYCLES + 1) : 1;
   localparam logic [KCW-1:0] KEEP_LOAD = KCW'(KEEPER_CYCLES);

   lane_state_e      state_q, state_d;
   logic [KCW-1:0]   keep_q, keep_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [PCW-1:0]   drivers;
   logic [WIDTH-1:0] sel;

   // Count active enables and OR together the enabled agents' values.
   always_comb begin
      drivers = '0;
      sel     = '0;
      for (int i = 0; i < NUM_AGENTS; i++) begin
         drivers = drivers + PCW'(lane_oe[i]);
         if (lane_oe[i]) sel = sel | lane_vals[i*WIDTH +: WIDTH];
      end
   end

   // Lane state from this cycle's driver count; keeper only continues out of DRIVEN/KEEPING.
   always_comb begin
      state_d        = FLOATING;
      keep_d         = '0;
      hold_d         = hold_q;
      lane_out       = UNDRIVEN_VALUE;
      lane_valid     = 1'b0;
      lane_contended = 1'b0;
      if (drivers == PCW'(1)) begin
         state_d    = DRIVEN;
         lane_out   = sel;
         lane_valid = 1'b1;
         hold_d     = sel;
         keep_d     = KEEP_LOAD;
      end else if (drivers == '0) begin
         if ((state_q == DRIVEN || state_q == KEEPING) && keep_q != '0) begin
            state_d    = KEEPING;
            lane_out   = hold_q;
            lane_valid = 1'b1;
            keep_d     = keep_q - KCW'(1);
         end
      end else begin
         // Fighting drivers: value is unknown and the keeper is invalidated.
         state_d        = CONTENDED;
         lane_out       = 'x;
         lane_contended = 1'b1;
      end
   end

   // Register lane state, keep counter and held value; reset drops any hold.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= FLOATING;
         keep_q  <= '0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         keep_q  <= keep_d;
         hold_q  <= hold_d;
      end
   end
endmodule

// File: rtl/mock_bus_n.sv
// N-agent simulation bus resolver with keeper decay and contention capture.
// Bus resolution zero latency; flags/counter/capture update one edge after contention.
// No backpressure; clear_i loses to same-cycle contention.
module mock_bus_n
   import mock_pkg::*;
#(
   parameter int NUM_AGENTS    = 4,
   parameter int ADDR_WIDTH    = common_pkg::CPU_ADDR_WIDTH,
   parameter int DATA_WIDTH    = common_pkg::DATA_WIDTH,
   parameter int KEEPER_CYCLES = 3,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                             clock_i,
   input  logic                             reset_n_i,
   input  logic [NUM_AGENTS*ADDR_WIDTH-1:0] agent_addr_i,
   input  logic [NUM_AGENTS-1:0]            agent_addr_oe_i,
   input  logic [NUM_AGENTS*DATA_WIDTH-1:0] agent_data_i,
   input  logic [NUM_AGENTS-1:0]            agent_data_oe_i,
   input  logic [NUM_AGENTS-1:0]            agent_we_n_i,
   input  logic [NUM_AGENTS-1:0]            agent_we_n_oe_i,
   input  logic                             clear_i,
   output logic [ADDR_WIDTH-1:0]            bus_addr_o,
   output logic [DATA_WIDTH-1:0]            bus_data_o,
   output logic                             bus_we_n_o,
   output logic [2:0]                       lane_valid_o,
   output logic [2:0]                       contention_o,
   output logic [2:0]                       contention_sticky_o,
   output logic [CNT_WIDTH-1:0]             contention_count_o,
   output logic [NUM_AGENTS-1:0]            first_mask_o,
   output logic [2:0]                       first_lane_o,
   output logic [31:0]                      first_cycle_o
);
   logic                  any_contention;
   logic                  captured_q;
   logic [NUM_AGENTS-1:0] offender_mask;
   logic [31:0]           cycle_q;

   mock_bus_lane #(.WIDTH(ADDR_WIDTH), .NUM_AGENTS(NUM_AGENTS), .KEEPER_CYCLES(KEEPER_CYCLES),
                   .UNDRIVEN_VALUE({ADDR_WIDTH{1'bx}})) u_addr (
      .clock(clock_i), .reset_n(reset_n_i), .lane_oe(agent_addr_oe_i), .lane_vals(agent_addr_i),
      .lane_out(bus_addr_o), .lane_valid(lane_valid_o[LANE_ADDR]),
      .lane_contended(contention_o[LANE_ADDR]));

   mock_bus_lane #(.WIDTH(DATA_WIDTH), .NUM_AGENTS(NUM_AGENTS), .KEEPER_CYCLES(KEEPER_CYCLES),
                   .UNDRIVEN_VALUE({DATA_WIDTH{1'bx}})) u_data (
      .clock(clock_i), .reset_n(reset_n_i), .lane_oe(agent_data_oe_i), .lane_vals(agent_data_i),
      .lane_out(bus_data_o), .lane_valid(lane_valid_o[LANE_DATA]),
      .lane_contended(contention_o[LANE_DATA]));

   // we_n is pulled up when nobody drives it, so it never floats to 'x.
   mock_bus_lane #(.WIDTH(1), .NUM_AGENTS(NUM_AGENTS), .KEEPER_CYCLES(KEEPER_CYCLES),
                   .UNDRIVEN_VALUE(1'b1)) u_we_n (
      .clock(clock_i), .reset_n(reset_n_i), .lane_oe(agent_we_n_oe_i), .lane_vals(agent_we_n_i),
      .lane_out(bus_we_n_o), .lane_valid(lane_valid_o[LANE_WE_N]),
      .lane_contended(contention_o[LANE_WE_N]));

   // Agents implicated in this cycle's contention: union of enables of contended lanes.
   always_comb begin
      any_contention = |contention_o;
      offender_mask  = '0;
      if (contention_o[LANE_ADDR]) offender_mask = offender_mask | agent_addr_oe_i;
      if (contention_o[LANE_DATA]) offender_mask = offender_mask | agent_data_oe_i;
      if (contention_o[LANE_WE_N]) offender_mask = offender_mask | agent_we_n_oe_i;
   end

   // Free-running cycle counter used to timestamp the first contention.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) cycle_q <= '0;
      else            cycle_q <= cycle_q + 32'd1;
   end

   // Sticky flags and saturating counter; same-cycle contention overrides clear.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         contention_sticky_o <= '0;
         contention_count_o  <= '0;
      end else begin
         contention_sticky_o <= (clear_i ? 3'b000 : contention_sticky_o) | contention_o;
         if (any_contention) begin
            if (clear_i)                         contention_count_o <= CNT_WIDTH'(1);
            else if (contention_count_o != '1)   contention_count_o <= contention_count_o + CNT_WIDTH'(1);
         end else if (clear_i) begin
            contention_count_o <= '0;
         end
      end
   end

   // First-offender capture: loads when empty (or being cleared), otherwise holds.
   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         captured_q    <= 1'b0;
         first_mask_o  <= '0;
         first_lane_o  <= '0;
         first_cycle_o <= '0;
      end else if (any_contention && (clear_i || !captured_q)) begin
         captured_q    <= 1'b1;
         first_mask_o  <= offender_mask;
         first_lane_o  <= contention_o;
         first_cycle_o <= cycle_q;
      end else if (clear_i) begin
         captured_q    <= 1'b0;
         first_mask_o  <= '0;
         first_lane_o  <= '0;
         first_cycle_o <= '0;
      end
   end
endmodule

// File: tb/tb_mock_bus_n.sv
// Directed bench for mock_bus_n with a per-cycle reference model and literal checkpoints.
module tb_mock_bus_n;
   import common_pkg::*;
   localparam int NA  = 4;
   localparam int AW  = CPU_ADDR_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int K   = 3;
   localparam int CW  = 16;
   localparam int BIG = 1000000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst_n;
   logic [NA*AW-1:0] a_val;
   logic [NA-1:0]    a_oe;
   logic [NA*DW-1:0] d_val;
   logic [NA-1:0]    d_oe;
   logic [NA-1:0]    w_val;
   logic [NA-1:0]    w_oe;
   logic             clear;

   logic [AW-1:0]    bus_addr;
   logic [DW-1:0]    bus_data;
   logic             bus_we_n;
   logic [2:0]       lane_valid, contention, sticky, first_lane;
   logic [CW-1:0]    count;
   logic [NA-1:0]    first_mask;
   logic [31:0]      first_cycle;

   mock_bus_n #(.NUM_AGENTS(NA), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .KEEPER_CYCLES(K), .CNT_WIDTH(CW)) dut (
      .clock_i(clk), .reset_n_i(rst_n),
      .agent_addr_i(a_val), .agent_addr_oe_i(a_oe),
      .agent_data_i(d_val), .agent_data_oe_i(d_oe),
      .agent_we_n_i(w_val), .agent_we_n_oe_i(w_oe),
      .clear_i(clear),
      .bus_addr_o(bus_addr), .bus_data_o(bus_data), .bus_we_n_o(bus_we_n),
      .lane_valid_o(lane_valid), .contention_o(contention),
      .contention_sticky_o(sticky), .contention_count_o(count),
      .first_mask_o(first_mask), .first_lane_o(first_lane), .first_cycle_o(first_cycle));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: undriven cycles since the last sole drive, plus bookkeeping registers.
   int            since [3];
   logic [AW-1:0] last_a;
   logic [DW-1:0] last_d;
   logic          last_w;
   logic [2:0]    m_sticky;
   int            m_count;
   logic          m_capv;
   logic [NA-1:0] m_mask;
   logic [2:0]    m_lane;
   logic [31:0]   m_first;
   logic [31:0]   m_cycle;
   bit            live = 1'b0;

   initial begin
      for (int l = 0; l < 3; l++) since[l] = BIG;
      last_a = '0; last_d = '0; last_w = 1'b1;
      m_sticky = '0; m_count = 0; m_capv = 1'b0; m_mask = '0; m_lane = '0; m_first = '0; m_cycle = '0;
   end

   always @(negedge clk) begin
      if (live) begin
         int pa, pd, pw;
         logic [2:0] ce, ve;
         logic [AW-1:0] drv_a;
         logic [DW-1:0] drv_d;
         logic drv_w;
         logic [NA-1:0] om;
         pa = $countones(a_oe); pd = $countones(d_oe); pw = $countones(w_oe);
         drv_a = '0; drv_d = '0; drv_w = 1'b0;
         for (int i = 0; i < NA; i++) begin
            if (a_oe[i]) drv_a = a_val[i*AW +: AW];
            if (d_oe[i]) drv_d = d_val[i*DW +: DW];
            if (w_oe[i]) drv_w = w_val[i];
         end
         ce = {pw > 1, pd > 1, pa > 1};
         ve = {pw == 1 || (pw == 0 && since[2] < K),
               pd == 1 || (pd == 0 && since[1] < K),
               pa == 1 || (pa == 0 && since[0] < K)};
         chk("contention", contention, ce);
         chk("lane_valid", lane_valid, ve);
         if (pa == 1)      chk("addr_driven", bus_addr, drv_a);
         else if (ve[0])   chk("addr_kept", bus_addr, last_a);
         if (pd == 1)      chk("data_driven", bus_data, drv_d);
         else if (ve[1])   chk("data_kept", bus_data, last_d);
         if (pw == 1)      chk("we_n_driven", bus_we_n, drv_w);
         else if (ve[2])   chk("we_n_kept", bus_we_n, last_w);
         else if (pw == 0) chk("we_n_pullup", bus_we_n, 1'b1);
         chk("sticky", sticky, m_sticky);
         chk("count", count, m_count[CW-1:0]);
         chk("first_mask", first_mask, m_mask);
         chk("first_lane", first_lane, m_lane);
         chk("first_cycle", first_cycle, m_first);

         // Advance the model to the state after the coming clock edge.
         if (!rst_n) begin
            for (int l = 0; l < 3; l++) since[l] = BIG;
            m_sticky = '0; m_count = 0; m_capv = 1'b0; m_mask = '0; m_lane = '0; m_first = '0; m_cycle = '0;
         end else begin
            om = (ce[0] ? a_oe : '0) | (ce[1] ? d_oe : '0) | (ce[2] ? w_oe : '0);
            m_sticky = (clear ? 3'b000 : m_sticky) | ce;
            if (ce != 0) begin
               m_count = clear ? 1 : ((m_count < (1 << CW) - 1) ? m_count + 1 : m_count);
               if (clear || !m_capv) begin
                  m_capv = 1'b1; m_mask = om; m_lane = ce; m_first = m_cycle;
               end
            end else if (clear) begin
               m_count = 0; m_capv = 1'b0; m_mask = '0; m_lane = '0; m_first = '0;
            end
            m_cycle = m_cycle + 32'd1;
            if (pa == 1) begin since[0] = 0; last_a = drv_a; end
            else if (pa == 0) begin if (since[0] < BIG) since[0]++; end
            else since[0] = BIG;
            if (pd == 1) begin since[1] = 0; last_d = drv_d; end
            else if (pd == 0) begin if (since[1] < BIG) since[1]++; end
            else since[1] = BIG;
            if (pw == 1) begin since[2] = 0; last_w = drv_w; end
            else if (pw == 0) begin if (since[2] < BIG) since[2]++; end
            else since[2] = BIG;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_cycle(input int c);
      int guard;
      guard = 0;
      while (m_cycle != 32'(c) && guard < 200) begin
         step();
         guard++;
      end
      chk("reach_cycle", m_cycle, 32'(c));
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0;
      a_oe = '0; d_oe = '0; w_oe = '0;
      a_val = {$urandom, $urandom}; d_val = $urandom; w_val = 4'b1010;
      @(posedge clk); @(posedge clk); #1;
      live = 1'b1;
      step();
      rst_n = 1'b1;
      #1;
      // Reset state, cycle 0.
      chk("rst_count", count, 16'h0000);
      chk("rst_sticky", sticky, 3'b000);
      chk("rst_mask", first_mask, 4'b0000);
      chk("rst_cycle", first_cycle, 32'd0);
      chk("rst_valid", lane_valid, 3'b000);
      chk("rst_we_n", bus_we_n, 1'b1);

      // Agent 2 drives 8'hA5 for one cycle at cycle 1, then releases.
      step();
      d_val = {8'h11, 8'hA5, 8'h22, 8'h33};
      d_oe  = 4'b0100;
      #1;
      chk("a5_driven", bus_data, 8'hA5);
      chk("a5_driven_valid", lane_valid[1], 1'b1);
      for (int j = 1; j <= 4; j++) begin
         step();
         d_oe = '0;
         #1;
         chk("a5_hold_valid", lane_valid[1], (j <= K) ? 1'b1 : 1'b0);
         if (j <= K) chk("a5_hold_value", bus_data, 8'hA5);
      end

      // we_n: undriven pulls up; agent 1 driving 0 resolves immediately.
      goto_cycle(6);
      #1;
      chk("we_n_float", bus_we_n, 1'b1);
      step();
      w_oe = 4'b0010; w_val = 4'b1101;
      #1;
      chk("we_n_driven0", bus_we_n, 1'b0);
      step();
      w_oe = '0;

      // Agents 0 and 3 fight on address at cycle 10.
      goto_cycle(10);
      a_val = {16'hBEEF, 16'h1234, 16'h5678, 16'hCAFE};
      a_oe  = 4'b1001;
      #1;
      chk("c10_contention", contention, 3'b001);
      step();
      a_oe = '0;
      #1;
      chk("c10_mask", first_mask, 4'b1001);
      chk("c10_lane", first_lane, 3'b001);
      chk("c10_cycle", first_cycle, 32'd10);
      chk("c10_count", count, 16'd1);
      chk("c10_sticky", sticky, 3'b001);

      // Data contention at 20,21,22, then clear coincident with contention at 23.
      goto_cycle(20);
      for (int j = 0; j < 4; j++) begin
         d_oe  = 4'b0110;
         clear = (j == 3);
         if (j == 3) begin
            #1;
            chk("pre_clear_count", count, 16'd4);
            chk("pre_clear_cycle", first_cycle, 32'd10);
         end
         step();
      end
      clear = 1'b0; d_oe = '0;
      #1;
      chk("clr_count", count, 16'd1);
      chk("clr_cycle", first_cycle, 32'd23);
      chk("clr_lane", first_lane, 3'b010);
      chk("clr_mask", first_mask, 4'b0110);
      chk("clr_sticky", sticky, 3'b010);

      // Clear alone empties everything.
      clear = 1'b1;
      step();
      clear = 1'b0;
      #1;
      chk("clear_count", count, 16'd0);
      chk("clear_sticky", sticky, 3'b000);
      chk("clear_mask", first_mask, 4'b0000);
      chk("clear_cycle", first_cycle, 32'd0);

      // Counter saturation over 2^16+5 contention cycles.
      a_oe = 4'b0011;
      repeat ((1 << CW) + 5) step();
      a_oe = '0;
      #1;
      chk("sat_count", count, 16'hFFFF);
      chk("sat_sticky", sticky, 3'b001);

      // Reset during KEEPING with hold 8'h3C.
      d_val = {8'h00, 8'h00, 8'h00, 8'h3C};
      d_oe  = 4'b0001;
      step();
      d_oe = '0;
      #1;
      chk("keep_3c", bus_data, 8'h3C);
      chk("keep_3c_valid", lane_valid[1], 1'b1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_valid", lane_valid[1], 1'b0);
      chk("post_rst_sticky", sticky, 3'b000);
      chk("post_rst_count", count, 16'd0);
      chk("post_rst_mask", first_mask, 4'b0000);
      chk("post_rst_lane", first_lane, 3'b000);
      chk("post_rst_cycle", first_cycle, 32'd0);

      repeat (3) step();
      live = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
